// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_pkg : shared MIPS datapath defaults and register-file clear FSM states |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package mips_pkg;

  localparam int DEF_LEN                  = 32;
  localparam int DEF_CANTIDAD_REGISTROS   = 32;
  localparam int DEF_NB_ADDRESS_REGISTROS = $clog2(DEF_CANTIDAD_REGISTROS);

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_CLEARING = 1'b1
  } estado_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/banco_registros_puerto_lectura.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | banco_registros_puerto_lectura : next-value select for one register read   |
// | port, with same-edge write bypass and optional hardwired-zero register 0.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module banco_registros_puerto_lectura
  import mips_pkg::*;
#(
  parameter int LEN                  = DEF_LEN,
  parameter int CANTIDAD_REGISTROS   = DEF_CANTIDAD_REGISTROS,
  parameter int NB_ADDRESS_REGISTROS = $clog2(CANTIDAD_REGISTROS),
  parameter int ZERO_REG             = 1
) (
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_addr,
  input  logic [LEN-1:0]                  i_array [CANTIDAD_REGISTROS],
  input  logic                            i_write_accept,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_write_addr,
  input  logic [LEN-1:0]                  i_write_data,
  output logic [LEN-1:0]                  o_next_data
);

  // Zero rule is applied last so it also masks a bypassed write to r0.
  always_comb begin
    o_next_data = i_array[i_addr];
    if (i_write_accept && (i_write_addr == i_addr)) begin
      o_next_data = i_write_data;
    end
    if ((ZERO_REG != 0) && (i_addr == '0)) begin
      o_next_data = '0;
    end
  end

endmodule : banco_registros_puerto_lectura
`default_nettype wire

// File: rtl/banco_registros_multipuerto.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | banco_registros_multipuerto : MIPS register file, N registered read ports, |
// | one write port, debug read port and sequential soft-clear engine.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module banco_registros_multipuerto
  import mips_pkg::*;
#(
  parameter int LEN                  = DEF_LEN,
  parameter int CANTIDAD_REGISTROS   = DEF_CANTIDAD_REGISTROS,
  parameter int NB_ADDRESS_REGISTROS = $clog2(CANTIDAD_REGISTROS),
  parameter int NB_READ_PORTS        = 2,
  parameter int ZERO_REG             = 1,
  parameter int INIT_INDEX           = 0
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst,
  input  logic [NB_READ_PORTS*NB_ADDRESS_REGISTROS-1:0] i_read_addr,
  output logic [NB_READ_PORTS*LEN-1:0]                  o_read_data,
  input  logic                                          i_write_enable,
  input  logic [NB_ADDRESS_REGISTROS-1:0]               i_write_addr,
  input  logic [LEN-1:0]                                i_write_data,
  input  logic                                          i_clear,
  output logic                                          o_busy,
  input  logic [NB_ADDRESS_REGISTROS-1:0]               i_debug_addr,
  output logic [LEN-1:0]                                o_debug_data
);

  localparam int                              NB_PORTS_TOTAL = NB_READ_PORTS + 1;
  localparam logic [NB_ADDRESS_REGISTROS-1:0] LAST_ENTRY     =
      NB_ADDRESS_REGISTROS'(CANTIDAD_REGISTROS - 1);

  function automatic logic [LEN-1:0] f_init_value(input int idx);
    if (INIT_INDEX != 0) begin
      return LEN'(idx);
    end
    return '0;
  endfunction

  logic [LEN-1:0]                  regs_q [CANTIDAD_REGISTROS];
  logic [LEN-1:0]                  regs_d [CANTIDAD_REGISTROS];
  estado_t                         state_q, state_d;
  logic [NB_ADDRESS_REGISTROS-1:0] cnt_q, cnt_d;
  logic [NB_READ_PORTS*LEN-1:0]    read_data_q, read_data_d;
  logic [LEN-1:0]                  debug_data_q, debug_data_d;

  logic                            w_write_accept;
  logic [NB_ADDRESS_REGISTROS-1:0] w_port_addr [NB_PORTS_TOTAL];
  logic [LEN-1:0]                  w_port_next [NB_PORTS_TOTAL];

  assign w_write_accept = i_write_enable && (state_q == ST_IDLE) &&
                          !((ZERO_REG != 0) && (i_write_addr == '0));

  // The last port slot serves the debug unit; it follows the same read rules.
  generate
    for (genvar k = 0; k < NB_PORTS_TOTAL; k++) begin : g_read_port
      if (k < NB_READ_PORTS) begin : g_data_port
        assign w_port_addr[k] = i_read_addr[k*NB_ADDRESS_REGISTROS +: NB_ADDRESS_REGISTROS];
      end else begin : g_debug_port
        assign w_port_addr[k] = i_debug_addr;
      end

      banco_registros_puerto_lectura #(
        .LEN                  (LEN),
        .CANTIDAD_REGISTROS   (CANTIDAD_REGISTROS),
        .NB_ADDRESS_REGISTROS (NB_ADDRESS_REGISTROS),
        .ZERO_REG             (ZERO_REG)
      ) u_puerto (
        .i_addr         (w_port_addr[k]),
        .i_array        (regs_q),
        .i_write_accept (w_write_accept),
        .i_write_addr   (i_write_addr),
        .i_write_data   (i_write_data),
        .o_next_data    (w_port_next[k])
      );
    end
  endgenerate

  always_comb begin
    read_data_d = '0;
    for (int k = 0; k < NB_READ_PORTS; k++) begin
      read_data_d[k*LEN +: LEN] = w_port_next[k];
    end
    debug_data_d = w_port_next[NB_READ_PORTS];
  end

  // Clear engine walks one entry per cycle; writes are only honoured in IDLE.
  always_comb begin
    regs_d  = regs_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_write_accept) begin
          regs_d[i_write_addr] = i_write_data;
        end
        if (i_clear) begin
          state_d = ST_CLEARING;
        end
      end
      ST_CLEARING: begin
        regs_d[cnt_q] = f_init_value(int'(cnt_q));
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == LAST_ENTRY) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < CANTIDAD_REGISTROS; i++) begin
        regs_q[i] <= f_init_value(i);
      end
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      read_data_q  <= '0;
      debug_data_q <= '0;
    end else begin
      regs_q       <= regs_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      read_data_q  <= read_data_d;
      debug_data_q <= debug_data_d;
    end
  end

  assign o_read_data  = read_data_q;
  assign o_debug_data = debug_data_q;
  assign o_busy       = (state_q == ST_CLEARING);

endmodule : banco_registros_multipuerto
`default_nettype wire

// File: tb/tb_banco_registros_multipuerto.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_banco_registros_multipuerto : randomized self-checking bench against a  |
// | behavioural register-file model (4 ports, zero reg, index init).           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_banco_registros_multipuerto;

  localparam int LEN = 32;
  localparam int NREG = 32;
  localparam int NA = 5;
  localparam int NP = 4;

  logic               i_clk;
  logic               i_rst;
  logic [NP*NA-1:0]   i_read_addr;
  logic [NP*LEN-1:0]  o_read_data;
  logic               i_write_enable;
  logic [NA-1:0]      i_write_addr;
  logic [LEN-1:0]     i_write_data;
  logic               i_clear;
  logic               o_busy;
  logic [NA-1:0]      i_debug_addr;
  logic [LEN-1:0]     o_debug_data;

  int checks = 0;
  int errors = 0;

  banco_registros_multipuerto #(
    .LEN                  (LEN),
    .CANTIDAD_REGISTROS   (NREG),
    .NB_ADDRESS_REGISTROS (NA),
    .NB_READ_PORTS        (NP),
    .ZERO_REG             (1),
    .INIT_INDEX           (1)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_read_addr    (i_read_addr),
    .o_read_data    (o_read_data),
    .i_write_enable (i_write_enable),
    .i_write_addr   (i_write_addr),
    .i_write_data   (i_write_data),
    .i_clear        (i_clear),
    .o_busy         (o_busy),
    .i_debug_addr   (i_debug_addr),
    .o_debug_data   (o_debug_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Behavioural model: array contents plus "clear in progress / next entry".
  logic [LEN-1:0] mdl [NREG];
  bit             m_clearing;
  int             m_clr_idx;
  logic [LEN-1:0] exp_rd [NP];
  logic [LEN-1:0] exp_dbg;
  logic           exp_busy;

  function automatic logic [LEN-1:0] ref_read(input int a, input bit acc, input int wa,
                                              input logic [LEN-1:0] wd);
    if (a == 0) return '0;
    if (acc && (wa == a)) return wd;
    return mdl[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) mdl[i] = 32'(i);
    m_clearing = 1'b0;
    m_clr_idx  = 0;
    for (int k = 0; k < NP; k++) exp_rd[k] = '0;
    exp_dbg  = '0;
    exp_busy = 1'b0;
  endtask

  task automatic set_ports(input int a0, input int a1, input int a2, input int a3, input int ad);
    i_read_addr  = {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    i_debug_addr = 5'(ad);
  endtask

  task automatic set_write(input bit we, input int wa, input logic [LEN-1:0] wd);
    i_write_enable = we;
    i_write_addr   = 5'(wa);
    i_write_data   = wd;
  endtask

  // Predict outputs from current inputs, advance the model, then clock the DUT.
  task automatic tick();
    bit acc;
    int wa;
    wa  = int'(i_write_addr);
    acc = (i_write_enable === 1'b1) && !m_clearing && (wa != 0);
    for (int k = 0; k < NP; k++)
      exp_rd[k] = ref_read(int'(i_read_addr[k*NA +: NA]), acc, wa, i_write_data);
    exp_dbg = ref_read(int'(i_debug_addr), acc, wa, i_write_data);
    if (m_clearing) begin
      mdl[m_clr_idx] = 32'(m_clr_idx);
      m_clr_idx++;
      if (m_clr_idx == NREG) begin
        m_clearing = 1'b0;
        m_clr_idx  = 0;
      end
    end else begin
      if (acc) mdl[wa] = i_write_data;
      if (i_clear === 1'b1) m_clearing = 1'b1;
    end
    exp_busy = m_clearing;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    set_ports(0, 0, 0, 0, 0);
    set_write(1'b0, 0, '0);
    i_clear = 1'b0;
    #1 i_rst = 1'b0;
    model_reset();
    repeat (2) begin
      #3;
      checks++;
      if (o_read_data !== '0) begin
        errors++;
        $display("FAIL reset_rd got %h want 0", o_read_data);
      end
      checks++;
      if (o_debug_data !== '0) begin
        errors++;
        $display("FAIL reset_dbg got %h want 0", o_debug_data);
      end
      checks++;
      if (o_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy got %b want 0", o_busy);
      end
      @(posedge i_clk);
    end
    #1;
    set_ports(5, 9, 0, 31, 17);
    i_rst = 1'b1;
    tick();
    for (int k = 0; k < NP; k++) begin
      checks++;
      if (o_read_data[k*LEN +: LEN] !== exp_rd[k]) begin
        errors++;
        $display("FAIL reset_init_rd%0d got %h want %h", k, o_read_data[k*LEN +: LEN], exp_rd[k]);
      end
    end
    checks++;
    if (o_read_data[LEN-1:0] !== 32'd5 || o_debug_data !== 32'd17) begin
      errors++;
      $display("FAIL reset_init_const got %h/%h want 5/17", o_read_data[LEN-1:0], o_debug_data);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_init_busy got %b want 0", o_busy);
    end
  endtask

  task automatic test_bypass();
    // Old r7 on both ports, then bypassed new value on port 0, then stored value on port 1.
    set_ports(7, 7, 1, 2, 7);
    set_write(1'b0, 0, '0);
    tick();
    checks++;
    if (o_read_data[2*LEN-1:LEN] !== 32'd7) begin
      errors++;
      $display("FAIL bypass_old got %h want 00000007", o_read_data[2*LEN-1:LEN]);
    end
    set_ports(7, 8, 1, 2, 7);
    set_write(1'b1, 7, 32'hDEADBEEF);
    tick();
    set_write(1'b0, 0, '0);
    for (int k = 0; k < NP; k++) begin
      checks++;
      if (o_read_data[k*LEN +: LEN] !== exp_rd[k]) begin
        errors++;
        $display("FAIL bypass_rd%0d got %h want %h", k, o_read_data[k*LEN +: LEN], exp_rd[k]);
      end
    end
    checks++;
    if (o_read_data[LEN-1:0] !== 32'hDEADBEEF || o_debug_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bypass_new got %h/%h want deadbeef", o_read_data[LEN-1:0], o_debug_data);
    end
    set_ports(3, 7, 1, 2, 0);
    tick();
    checks++;
    if (o_read_data[2*LEN-1:LEN] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bypass_stored got %h want deadbeef", o_read_data[2*LEN-1:LEN]);
    end
  endtask

  task automatic test_zero_reg();
    set_ports(0, 0, 0, 0, 0);
    set_write(1'b1, 0, 32'h1234);
    tick();
    set_write(1'b0, 0, '0);
    checks++;
    if (o_read_data !== '0 || o_debug_data !== '0) begin
      errors++;
      $display("FAIL zero_same got %h/%h want 0", o_read_data, o_debug_data);
    end
    tick();
    checks++;
    if (o_read_data !== '0 || o_debug_data !== '0) begin
      errors++;
      $display("FAIL zero_next got %h/%h want 0", o_read_data, o_debug_data);
    end
  endtask

  task automatic test_all_ports();
    set_ports(12, 12, 12, 12, 12);
    set_write(1'b1, 12, 32'hA5);
    tick();
    set_write(1'b0, 0, '0);
    for (int k = 0; k < NP; k++) begin
      checks++;
      if (o_read_data[k*LEN +: LEN] !== 32'hA5) begin
        errors++;
        $display("FAIL allports_rd%0d got %h want 000000a5", k, o_read_data[k*LEN +: LEN]);
      end
    end
    checks++;
    if (o_debug_data !== 32'hA5) begin
      errors++;
      $display("FAIL allports_dbg got %h want 000000a5", o_debug_data);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 8; i++) begin
      set_ports(i - 1, i, 20 + i, i, i - 1);
      set_write(1'b1, i, $urandom);
      tick();
      for (int k = 0; k < NP; k++) begin
        checks++;
        if (o_read_data[k*LEN +: LEN] !== exp_rd[k]) begin
          errors++;
          $display("FAIL b2b_rd%0d i=%0d got %h want %h", k, i, o_read_data[k*LEN +: LEN], exp_rd[k]);
        end
      end
      checks++;
      if (o_debug_data !== exp_dbg) begin
        errors++;
        $display("FAIL b2b_dbg i=%0d got %h want %h", i, o_debug_data, exp_dbg);
      end
    end
    set_write(1'b0, 0, '0);
  endtask

  task automatic test_clear();
    set_ports(3, 0, 0, 0, 3);
    set_write(1'b1, 3, 32'hCAFE);
    tick();
    set_write(1'b0, 0, '0);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    for (int c = 1; c <= NREG; c++) begin
      checks++;
      if (o_busy !== (c <= NREG - 1 ? 1'b1 : 1'b0) && c != NREG) begin
        errors++;
        $display("FAIL clear_busy cyc=%0d got %b want 1", c, o_busy);
      end
      if (c == 10) begin
        set_write(1'b1, 3, 32'h55);
        i_clear = 1'b1;
      end else begin
        set_write(1'b0, 0, '0);
        i_clear = 1'b0;
      end
      set_ports($urandom_range(0, 31), $urandom_range(0, 31), 3, $urandom_range(0, 31), 3);
      tick();
      for (int k = 0; k < NP; k++) begin
        checks++;
        if (o_read_data[k*LEN +: LEN] !== exp_rd[k]) begin
          errors++;
          $display("FAIL clear_rd%0d cyc=%0d got %h want %h", k, c, o_read_data[k*LEN +: LEN], exp_rd[k]);
        end
      end
    end
    i_clear = 1'b0;
    set_write(1'b0, 0, '0);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_done_busy got %b want 0", o_busy);
    end
    for (int r = 0; r < NREG; r++) begin
      set_ports(r, 0, 0, 0, r);
      tick();
      checks++;
      if (o_debug_data !== 32'(r)) begin
        errors++;
        $display("FAIL clear_init r%0d got %h want %h", r, o_debug_data, 32'(r));
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    set_ports(31, 0, 0, 0, 31);
    set_write(1'b1, 31, 32'h77);
    tick();
    set_write(1'b0, 0, '0);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    repeat (10) tick();
    checks++;
    if (o_busy !== 1'b1 || o_read_data[LEN-1:0] !== 32'h77) begin
      errors++;
      $display("FAIL midclear_pre got busy=%b rd=%h want 1/00000077", o_busy, o_read_data[LEN-1:0]);
    end
    #2 i_rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL midclear_busy got %b want 0", o_busy);
    end
    checks++;
    if (o_read_data !== '0 || o_debug_data !== '0) begin
      errors++;
      $display("FAIL midclear_data got %h/%h want 0", o_read_data, o_debug_data);
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    tick();
    checks++;
    if (o_read_data[LEN-1:0] !== 32'd31 || o_debug_data !== 32'd31 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL midclear_r31 got %h/%h busy=%b want 1f/1f/0", o_read_data[LEN-1:0], o_debug_data, o_busy);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      set_ports($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 31));
      set_write(1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom);
      i_clear = ($urandom_range(0, 39) == 0);
      tick();
      for (int k = 0; k < NP; k++) begin
        checks++;
        if (o_read_data[k*LEN +: LEN] !== exp_rd[k]) begin
          errors++;
          $display("FAIL random_rd%0d n=%0d got %h want %h", k, n, o_read_data[k*LEN +: LEN], exp_rd[k]);
        end
      end
      checks++;
      if (o_debug_data !== exp_dbg || o_busy !== exp_busy) begin
        errors++;
        $display("FAIL random_dbg_busy n=%0d got %h/%b want %h/%b", n, o_debug_data, o_busy, exp_dbg, exp_busy);
      end
    end
    i_clear = 1'b0;
    set_write(1'b0, 0, '0);
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_all_ports();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_banco_registros_multipuerto
`default_nettype wire
